// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: decodes {RW,ADDR} command bytes and runs single/burst
// register accesses, feeding status and read data back to the byte engine.
module spi_cmd_ctrl #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF,
  parameter int unsigned AUTO_INC  = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err_ovr,
  output logic              err_tmo,
  input  logic              err_clr
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, WR_BUS, RD_BUS, RD_WAIT, HALT} state_t;

  state_t      state, state_n;
  logic        ss_m, ss_s, ss_d;
  logic        buf_vld, ovr_pend;
  logic [7:0]  buf_data, tmo_cnt;
  logic        ss_rise, in_bus, byte_vld;
  logic [7:0]  byte_in;
  logic        ld_status, ld_idle, ld_rd, tmo_hit, ovr_hit;
  logic        addr_ld, addr_inc, wd_ld, take;

  assign ss_rise  = ss_s & ~ss_d;
  assign in_bus   = (state == WR_BUS) || (state == RD_BUS);
  // A buffered byte is older than one arriving this cycle, so it goes first.
  assign byte_vld = rx_valid | buf_vld;
  assign byte_in  = buf_vld ? buf_data : rx_data;
  assign bus_req  = in_bus;
  assign bus_we   = (state == WR_BUS);
  assign busy     = (state != IDLE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ld_status = 1'b0;
    ld_idle   = 1'b0;
    ld_rd     = 1'b0;
    tmo_hit   = 1'b0;
    ovr_hit   = 1'b0;
    addr_ld   = 1'b0;
    addr_inc  = 1'b0;
    wd_ld     = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: if (ss_rise) begin
        state_n   = CMD;
        ld_status = 1'b1;
      end
      CMD: if (!ss_s) state_n = IDLE;
        else if (byte_vld) begin
          take    = 1'b1;
          addr_ld = 1'b1;
          state_n = byte_in[7] ? WDATA : RD_BUS;
        end
      WDATA: if (!ss_s) state_n = IDLE;
        else if (byte_vld) begin
          take    = 1'b1;
          wd_ld   = 1'b1;
          ld_idle = 1'b1;
          state_n = WR_BUS;
        end
      WR_BUS, RD_BUS: begin
        ovr_hit = rx_valid & buf_vld;
        if (bus_ack) begin
          addr_inc = (state == WR_BUS);
          if (!ss_s)                      state_n = IDLE;
          else if (ovr_pend || ovr_hit)   state_n = HALT;
          else if (state == WR_BUS)       state_n = WDATA;
          else begin
            ld_rd   = 1'b1;
            state_n = RD_WAIT;
          end
        end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_n = ss_s ? HALT : IDLE;
        end
      end
      RD_WAIT: if (!ss_s) state_n = IDLE;
        else if (byte_vld) begin
          take     = 1'b1;
          addr_inc = 1'b1;
          state_n  = RD_BUS;
        end
      HALT: if (!ss_s) state_n = IDLE;
        else if (rx_valid) ld_idle = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_m      <= 1'b0;
      ss_s      <= 1'b0;
      ss_d      <= 1'b0;
      buf_vld   <= 1'b0;
      buf_data  <= 8'h00;
      ovr_pend  <= 1'b0;
      tmo_cnt   <= 8'h00;
      tx_load   <= 1'b0;
      tx_data   <= IDLE_BYTE;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
      err_ovr   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      ss_m <= ss;
      ss_s <= ss_m;
      ss_d <= ss_s;
      // Flush on frame end or abort; otherwise a consumed entry is refilled by a same-cycle byte.
      if (state_n == IDLE || state_n == HALT) buf_vld <= 1'b0;
      else if (take) begin
        if (buf_vld) begin
          buf_vld  <= rx_valid;
          buf_data <= rx_data;
        end
      end else if (in_bus && rx_valid && !buf_vld) begin
        buf_vld  <= 1'b1;
        buf_data <= rx_data;
      end
      ovr_pend <= in_bus && (ovr_pend || ovr_hit) && (state_n == state);
      tmo_cnt  <= (in_bus && state_n == state) ? tmo_cnt + 8'd1 : 8'h00;
      tx_load  <= ld_status | ld_idle | ld_rd;
      if (ld_status)    tx_data <= {6'b0, err_ovr, err_tmo};
      else if (ld_idle) tx_data <= IDLE_BYTE;
      else if (ld_rd)   tx_data <= bus_rdata;
      if (addr_ld)       bus_addr <= byte_in[ADDR_W-1:0];
      else if (addr_inc) bus_addr <= bus_addr + ADDR_W'(AUTO_INC);
      if (wd_ld) bus_wdata <= byte_in;
      if (ovr_hit)      err_ovr <= 1'b1;
      else if (err_clr) err_ovr <= 1'b0;
      if (tmo_hit)      err_tmo <= 1'b1;
      else if (err_clr) err_tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: directed frames push expected tx bytes and
// bus accesses; a monitor pops and compares as the DUT presents them.
module tb_spi_cmd_ctrl;
  typedef struct {logic we; logic [6:0] addr; logic [7:0] wd;} bus_t;

  logic       sys_clk = 0, rst_n = 0, ss = 0, rx_valid = 0, err_clr = 0;
  logic [7:0] rx_data = 0, bus_rdata, tx_data, bus_wdata;
  logic       bus_ack, tx_load, bus_req, bus_we, busy, err_ovr, err_tmo;
  logic [6:0] bus_addr;

  int checks = 0, errors = 0;
  int ack_lat = -1, wait_cnt = 0, req_len = 0;
  logic prev_req = 0;
  logic [7:0] tx_q[$];
  bus_t       bus_q[$];
  logic [7:0] rd_q[$];

  spi_cmd_ctrl dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .ss(ss), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .err_ovr(err_ovr), .err_tmo(err_tmo), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register-bus responder: ack after ack_lat idle cycles; ack_lat < 0 never acks.
  initial begin
    bus_ack = 0; bus_rdata = 0;
    forever begin
      @(negedge sys_clk);
      if (bus_req && !bus_ack && ack_lat >= 0) begin
        if (wait_cnt >= ack_lat) begin
          bus_ack = 1;
          bus_rdata = (!bus_we && rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
          wait_cnt = 0;
        end else wait_cnt++;
      end else begin
        bus_ack = 0;
        if (!bus_req) wait_cnt = 0;
      end
    end
  end

  // Monitor: compare every tx_load and every new bus request against the queues.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n) begin
        if (tx_load) begin
          if (tx_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hDEAD);
          else chk("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
        end
        if (bus_req && !prev_req) begin
          req_len = 1;
          if (bus_q.size() == 0) chk("bus_unexpected", {31'h0, bus_we}, 32'hDEAD);
          else begin
            bus_t e;
            e = bus_q.pop_front();
            chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
            chk("bus_addr", {25'h0, bus_addr}, {25'h0, e.addr});
            if (e.we) chk("bus_wdata", {24'h0, bus_wdata}, {24'h0, e.wd});
          end
        end else if (bus_req) req_len++;
      end
      prev_req = bus_req;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1; rx_data = b;
    @(negedge sys_clk);
    rx_valid = 0;
    cyc(gap);
  endtask

  task automatic frame_start(input logic [7:0] status);
    tx_q.push_back(status);
    ss = 1;
    cyc(5);
  endtask

  task automatic frame_end();
    ss = 0;
    cyc(5);
    chk("idle_after_frame", {31'h0, busy}, 32'h0);
  endtask

  task automatic expect_bus(input logic we, input logic [6:0] a, input logic [7:0] wd);
    bus_t e;
    e.we = we; e.addr = a; e.wd = wd;
    bus_q.push_back(e);
  endtask

  initial begin
    #12;
    chk("rst_tx_data", {24'h0, tx_data}, 32'hFF);
    chk("rst_outs", {26'h0, tx_load, bus_req, bus_we, busy, err_ovr, err_tmo}, 32'h0);
    chk("rst_addr_wd", {17'h0, bus_addr, bus_wdata}, 32'h0);
    rst_n = 1;
    cyc(2);

    // Single write: 85 3C -> write 3C to 05
    ack_lat = 0;
    frame_start(8'h00);
    send_byte(8'h85, 6);
    tx_q.push_back(8'hFF);
    expect_bus(1, 7'h05, 8'h3C);
    send_byte(8'h3C, 6);
    chk("wr_back_wdata", {31'h0, busy}, 32'h1);
    frame_end();

    // Burst read with address wrap 7E,7F,00
    ack_lat = 1;
    frame_start(8'h00);
    expect_bus(0, 7'h7E, 8'h0); rd_q.push_back(8'hA1); tx_q.push_back(8'hA1);
    send_byte(8'h7E, 6);
    expect_bus(0, 7'h7F, 8'h0); rd_q.push_back(8'hA2); tx_q.push_back(8'hA2);
    send_byte(8'h00, 6);
    expect_bus(0, 7'h00, 8'h0); rd_q.push_back(8'hA3); tx_q.push_back(8'hA3);
    send_byte(8'h00, 6);
    frame_end();

    // Timeout: req held 15 cycles, err_tmo, HALT
    ack_lat = -1;
    frame_start(8'h00);
    send_byte(8'h90, 4);
    tx_q.push_back(8'hFF);
    expect_bus(1, 7'h10, 8'h55);
    send_byte(8'h55, 20);
    chk("tmo_req_len", req_len, 15);
    chk("tmo_req_low", {31'h0, bus_req}, 32'h0);
    chk("tmo_err", {31'h0, err_tmo}, 32'h1);
    chk("tmo_halt_busy", {31'h0, busy}, 32'h1);
    tx_q.push_back(8'hFF);
    send_byte(8'h12, 3);
    frame_end();
    frame_start(8'h01);
    frame_end();
    err_clr = 1; cyc(1); err_clr = 0; cyc(1);
    chk("tmo_clr", {30'h0, err_ovr, err_tmo}, 32'h0);

    // Overrun: two bytes land while the write stalls
    frame_start(8'h00);
    send_byte(8'h81, 4);
    tx_q.push_back(8'hFF);
    expect_bus(1, 7'h01, 8'h11);
    send_byte(8'h11, 0);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    chk("ovr_flag", {31'h0, err_ovr}, 32'h1);
    ack_lat = 0;
    cyc(4);
    chk("ovr_halt", {29'h0, busy, bus_req, err_tmo}, 32'h4);
    tx_q.push_back(8'hFF);
    send_byte(8'h34, 3);
    frame_end();
    err_clr = 1; cyc(1); err_clr = 0; cyc(1);
    chk("ovr_clr", {30'h0, err_ovr, err_tmo}, 32'h0);

    // ss falls during a read: access completes, no tx_load, fresh decode next frame
    ack_lat = 8;
    frame_start(8'h00);
    expect_bus(0, 7'h05, 8'h0); rd_q.push_back(8'h77);
    send_byte(8'h05, 0);
    ss = 0;
    cyc(3);
    chk("ssfall_req_held", {31'h0, bus_req}, 32'h1);
    cyc(10);
    chk("ssfall_idle", {30'h0, busy, bus_req}, 32'h0);
    ack_lat = 1;
    frame_start(8'h00);
    send_byte(8'h85, 6);
    tx_q.push_back(8'hFF);
    expect_bus(1, 7'h05, 8'h42);
    send_byte(8'h42, 6);
    frame_end();

    // Async reset in the middle of a stalled write
    ack_lat = -1;
    frame_start(8'h00);
    send_byte(8'h83, 4);
    tx_q.push_back(8'hFF);
    expect_bus(1, 7'h03, 8'h99);
    send_byte(8'h99, 3);
    chk("pre_rst_req", {31'h0, bus_req}, 32'h1);
    #1 rst_n = 0; ss = 0;
    #1;
    chk("arst_outs", {26'h0, tx_load, bus_req, bus_we, busy, err_ovr, err_tmo}, 32'h0);
    chk("arst_tx_data", {24'h0, tx_data}, 32'hFF);
    chk("arst_addr_wd", {17'h0, bus_addr, bus_wdata}, 32'h0);
    cyc(2);
    rst_n = 1;
    cyc(5);

    chk("tx_q_drained", tx_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
